// File: rtl/sdram_byte_bridge.sv
// Byte-wide CPU/DMA port onto one toggle-handshake port of the dual-port SDRAM controller.
// A one-word read cache lets repeated byte reads within the same word complete without an SDRAM slot.
module sdram_byte_bridge #(
   parameter int CACHE_EN = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [23:0] cpu_a,
   input  logic [7:0]  cpu_d,
   output logic [7:0]  cpu_q,
   output logic        cpu_valid,
   output logic        cpu_busy,
   input  logic        cache_inv,
   output logic        mem_req,
   input  logic        mem_ack,
   output logic        mem_we,
   output logic [22:0] mem_a,
   output logic [1:0]  mem_ds,
   output logic [15:0] mem_d,
   input  logic [15:0] mem_q
);
   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t      state_q, state_d;
   logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d;
   logic [22:0] mem_a_q, mem_a_d;
   logic [1:0]  mem_ds_q, mem_ds_d;
   logic [15:0] mem_d_q, mem_d_d;
   logic [7:0]  cpu_q_q, cpu_q_d;
   logic        cpu_valid_q, cpu_valid_d, cpu_busy_q, cpu_busy_d;
   logic        sel_q, sel_d;
   logic        valid_q, valid_d;
   logic [22:0] tag_q, tag_d;
   logic [15:0] line_q, line_d;
   logic        hit, done;

   assign hit  = (CACHE_EN != 0) && valid_q && (tag_q == cpu_a[23:1]) && !cache_inv;
   assign done = (mem_req_q == mem_ack);

   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_a_d     = mem_a_q;
      mem_ds_d    = mem_ds_q;
      mem_d_d     = mem_d_q;
      cpu_q_d     = cpu_q_q;
      cpu_valid_d = 1'b0;
      cpu_busy_d  = cpu_busy_q;
      sel_d       = sel_q;
      valid_d     = valid_q && !cache_inv;
      tag_d       = tag_q;
      line_d      = line_q;
      case (state_q)
         S_IDLE: begin
            if (cpu_req) begin
               if (!cpu_we && hit) begin
                  cpu_q_d     = cpu_a[0] ? line_q[15:8] : line_q[7:0];
                  cpu_valid_d = 1'b1;
               end else begin
                  mem_a_d    = cpu_a[23:1];
                  mem_we_d   = cpu_we;
                  mem_d_d    = {cpu_d, cpu_d};
                  mem_ds_d   = cpu_we ? (cpu_a[0] ? 2'b10 : 2'b01) : 2'b11;
                  sel_d      = cpu_a[0];
                  mem_req_d  = ~mem_req_q;
                  cpu_busy_d = 1'b1;
                  state_d    = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            // new requests are dropped here, including on the completion cycle
            if (done) begin
               cpu_valid_d = 1'b1;
               cpu_busy_d  = 1'b0;
               state_d     = S_IDLE;
               if (!mem_we_q) begin
                  cpu_q_d = sel_q ? mem_q[15:8] : mem_q[7:0];
                  if (CACHE_EN != 0) begin
                     line_d  = mem_q;
                     tag_d   = mem_a_q;
                     valid_d = !cache_inv;
                  end
               end else if ((CACHE_EN != 0) && valid_q && (tag_q == mem_a_q)) begin
                  if (sel_q) line_d[15:8] = mem_d_q[7:0];
                  else       line_d[7:0]  = mem_d_q[7:0];
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_a_q     <= '0;
         mem_ds_q    <= '0;
         mem_d_q     <= '0;
         cpu_q_q     <= '0;
         cpu_valid_q <= 1'b0;
         cpu_busy_q  <= 1'b0;
         sel_q       <= 1'b0;
         valid_q     <= 1'b0;
         tag_q       <= '0;
         line_q      <= '0;
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_a_q     <= mem_a_d;
         mem_ds_q    <= mem_ds_d;
         mem_d_q     <= mem_d_d;
         cpu_q_q     <= cpu_q_d;
         cpu_valid_q <= cpu_valid_d;
         cpu_busy_q  <= cpu_busy_d;
         sel_q       <= sel_d;
         valid_q     <= valid_d;
         tag_q       <= tag_d;
         line_q      <= line_d;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_a     = mem_a_q;
   assign mem_ds    = mem_ds_q;
   assign mem_d     = mem_d_q;
   assign cpu_q     = cpu_q_q;
   assign cpu_valid = cpu_valid_q;
   assign cpu_busy  = cpu_busy_q;
endmodule
